// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiter: FSM states, address regions,
// decode bounds and the value returned for unmapped reads.
package bus_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_WRITE = 2'd1,
        BUS_READ  = 2'd2,
        BUS_DONE  = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        REG_NONE = 2'd0,
        REG_RAM  = 2'd1,
        REG_ROM  = 2'd2,
        REG_IO   = 2'd3
    } region_e;

    localparam logic [1:0]  ROM_BASE_HI = 2'b11;
    localparam logic [7:0]  IO_PAGE     = 8'h92;
    localparam logic [15:0] RAM_TOP     = 16'h8FFF;
    localparam logic [7:0]  UNMAPPED_RD = 8'hFF;

endpackage

// File: rtl/bus_decode.sv
// Combinational address-to-region decode; ROM wins over IO, IO wins over RAM.
module bus_decode
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] addr,
    output region_e           region_c
);

    always_comb begin
        region_c = REG_NONE;
        if (addr[ADDR_W-1 -: 2] == ROM_BASE_HI) begin
            region_c = REG_ROM;
        end else if (addr[ADDR_W-1 -: 8] == IO_PAGE) begin
            region_c = REG_IO;
        end else if (addr <= ADDR_W'(RAM_TOP)) begin
            region_c = REG_RAM;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus controller sequencing transfers onto RAM, ROM and
// the 0x92xx I/O window, with read wait states and a one-cycle ready pulse.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic              m0_rd_req,
    input  logic              m0_wr_en,
    input  logic [DATA_W-1:0] m0_wr_data,
    output logic [DATA_W-1:0] m0_rd_data,
    output logic              m0_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_rd_req,
    input  logic              m1_wr_en,
    input  logic [DATA_W-1:0] m1_wr_data,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              m1_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              ram_we,
    output logic              io_we,
    input  logic [DATA_W-1:0] ram_rd_data,
    input  logic [DATA_W-1:0] rom_rd_data,
    input  logic [DATA_W-1:0] io_rd_data
);

    localparam int unsigned CNT_W = 3;

    bus_state_e        state_q, state_d;
    region_e           region_q, region_d;
    region_e           sel_region_c;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wr_data_d;
    logic [DATA_W-1:0] m0_rd_data_d, m1_rd_data_d;
    logic              m0_ready_d, m1_ready_d;
    logic              ram_we_d, io_we_d;
    logic              req0_c, req1_c, sel_c, sel_wr_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] sel_wr_data_c;
    logic [DATA_W-1:0] rd_mux_c;

    // Request arbitration: a tie goes to the master opposite the last grant.
    assign req0_c        = m0_rd_req | m0_wr_en;
    assign req1_c        = m1_rd_req | m1_wr_en;
    assign sel_c         = (req0_c & req1_c) ? ~last_grant_q : req1_c;
    assign sel_addr_c    = sel_c ? m1_addr    : m0_addr;
    assign sel_wr_data_c = sel_c ? m1_wr_data : m0_wr_data;
    assign sel_wr_c      = sel_c ? m1_wr_en   : m0_wr_en;

    bus_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr     (sel_addr_c),
        .region_c (sel_region_c)
    );

    always_comb begin
        rd_mux_c = DATA_W'(UNMAPPED_RD);
        case (region_q)
            REG_RAM: rd_mux_c = ram_rd_data;
            REG_ROM: rd_mux_c = rom_rd_data;
            REG_IO:  rd_mux_c = io_rd_data;
            default: rd_mux_c = DATA_W'(UNMAPPED_RD);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BUS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and next register values; strobes and ready are one-cycle by default.
    always_comb begin
        state_d       = state_q;
        region_d      = region_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        mem_addr_d    = mem_addr;
        mem_wr_data_d = mem_wr_data;
        m0_rd_data_d  = m0_rd_data;
        m1_rd_data_d  = m1_rd_data;
        m0_ready_d    = 1'b0;
        m1_ready_d    = 1'b0;
        ram_we_d      = 1'b0;
        io_we_d       = 1'b0;

        case (state_q)
            BUS_IDLE: begin
                if (req0_c | req1_c) begin
                    grant_d       = sel_c;
                    last_grant_d  = sel_c;
                    mem_addr_d    = sel_addr_c;
                    mem_wr_data_d = sel_wr_data_c;
                    region_d      = sel_region_c;
                    cnt_d         = '0;
                    if (sel_wr_c) begin
                        state_d  = BUS_WRITE;
                        ram_we_d = (sel_region_c == REG_RAM);
                        io_we_d  = (sel_region_c == REG_IO);
                    end else begin
                        state_d = BUS_READ;
                    end
                end
            end
            BUS_WRITE: begin
                state_d    = BUS_DONE;
                m0_ready_d = ~grant_q;
                m1_ready_d = grant_q;
            end
            // One address-launch cycle, then RD_WAIT cycles of slave q latency.
            BUS_READ: begin
                if (cnt_q == CNT_W'(RD_WAIT)) begin
                    state_d    = BUS_DONE;
                    m0_ready_d = ~grant_q;
                    m1_ready_d = grant_q;
                    if (grant_q) begin
                        m1_rd_data_d = rd_mux_c;
                    end else begin
                        m0_rd_data_d = rd_mux_c;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BUS_DONE: begin
                state_d = BUS_IDLE;
            end
            default: begin
                state_d = BUS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            region_q     <= REG_NONE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            mem_addr     <= '0;
            mem_wr_data  <= '0;
            m0_rd_data   <= '0;
            m1_rd_data   <= '0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            ram_we       <= 1'b0;
            io_we        <= 1'b0;
        end else begin
            region_q     <= region_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_addr     <= mem_addr_d;
            mem_wr_data  <= mem_wr_data_d;
            m0_rd_data   <= m0_rd_data_d;
            m1_rd_data   <= m1_rd_data_d;
            m0_ready     <= m0_ready_d;
            m1_ready     <= m1_ready_d;
            ram_we       <= ram_we_d;
            io_we        <= io_we_d;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with synchronous RAM/ROM/IO slave models
// (one-cycle q latency) and a table of single-master transactions.
module tb_bus_arbiter;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RD_WAIT = 1;

    logic              clk;
    logic              reset_n;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic              m0_rd_req, m0_wr_en, m1_rd_req, m1_wr_en;
    logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
    logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
    logic              m0_ready, m1_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              ram_we, io_we;
    logic [DATA_W-1:0] ram_q, rom_q, io_q;

    logic [7:0] ram     [0:65535];
    logic [7:0] rom     [0:16383];
    logic [7:0] io_regs [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    bus_arbiter #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RD_WAIT (RD_WAIT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .m0_addr     (m0_addr),
        .m0_rd_req   (m0_rd_req),
        .m0_wr_en    (m0_wr_en),
        .m0_wr_data  (m0_wr_data),
        .m0_rd_data  (m0_rd_data),
        .m0_ready    (m0_ready),
        .m1_addr     (m1_addr),
        .m1_rd_req   (m1_rd_req),
        .m1_wr_en    (m1_wr_en),
        .m1_wr_data  (m1_wr_data),
        .m1_rd_data  (m1_rd_data),
        .m1_ready    (m1_ready),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .ram_we      (ram_we),
        .io_we       (io_we),
        .ram_rd_data (ram_q),
        .rom_rd_data (rom_q),
        .io_rd_data  (io_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous slaves: address sampled on the clock edge, q valid one cycle later.
    always @(posedge clk) begin
        ram_q <= ram[mem_addr];
        rom_q <= rom[mem_addr[13:0]];
        io_q  <= io_regs[mem_addr[7:0]];
        if (ram_we) ram[mem_addr] <= mem_wr_data;
        if (io_we)  io_regs[mem_addr[7:0]] <= mem_wr_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        m0_rd_req = 1'b0; m0_wr_en = 1'b0;
        m1_rd_req = 1'b0; m1_wr_en = 1'b0;
    endtask

    // One transaction from one master; cycle 0 is the idle cycle the request is first seen.
    task automatic run_txn(input bit m, input logic [15:0] a, input logic rd, input logic wr,
                           input logic [7:0] wd, output int lat, output logic [7:0] rdat,
                           output int ram_n, output int io_n, output logic [15:0] addr1,
                           output bit other_rdy, output bit pulse_ok);
        @(negedge clk);
        if (!m) begin
            m0_addr = a; m0_rd_req = rd; m0_wr_en = wr; m0_wr_data = wd;
        end else begin
            m1_addr = a; m1_rd_req = rd; m1_wr_en = wr; m1_wr_data = wd;
        end
        lat = -1; rdat = 8'h00; ram_n = 0; io_n = 0; addr1 = 16'h0; other_rdy = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) addr1 = mem_addr;
            ram_n = ram_n + int'(ram_we);
            io_n  = io_n + int'(io_we);
            if (m ? m0_ready : m1_ready) other_rdy = 1'b1;
            if (m ? m1_ready : m0_ready) begin
                lat  = c;
                rdat = m ? m1_rd_data : m0_rd_data;
                break;
            end
        end
        clear_reqs();
        @(negedge clk);
        pulse_ok = !(m0_ready | m1_ready);
    endtask

    typedef struct {
        bit          m;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  wd;
        int          lat;
        logic [7:0]  rdat;
        int          ram_n;
        int          io_n;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int          lat, ram_n, io_n, rst_rdy, n_ev;
        logic [7:0]  rdat;
        logic [15:0] addr1;
        bit          other_rdy, pulse_ok;
        bit          ev_m [4];
        int          ev_c [4];
        logic [7:0]  ev_d [4];

        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        for (int i = 0; i < 16384; i++) rom[i] = 8'h00;
        for (int i = 0; i < 256; i++)   io_regs[i] = 8'h00;
        ram[16'h1234] = 8'h5A;
        ram[16'h8FFF] = 8'h11;
        rom[14'h0000] = 8'h4C;

        vecs[0]  = '{1'b0, 16'h1234, 1'b1, 1'b0, 8'h00, 3, 8'h5A, 0, 0};
        vecs[1]  = '{1'b0, 16'h9203, 1'b0, 1'b1, 8'hA5, 2, 8'h5A, 0, 1};
        vecs[2]  = '{1'b0, 16'hC010, 1'b0, 1'b1, 8'h77, 2, 8'h5A, 0, 0};
        vecs[3]  = '{1'b0, 16'hA000, 1'b1, 1'b0, 8'h00, 3, 8'hFF, 0, 0};
        vecs[4]  = '{1'b0, 16'hC000, 1'b1, 1'b0, 8'h00, 3, 8'h4C, 0, 0};
        vecs[5]  = '{1'b1, 16'h0100, 1'b1, 1'b1, 8'h33, 2, 8'h00, 1, 0};
        vecs[6]  = '{1'b1, 16'h0100, 1'b1, 1'b0, 8'h00, 3, 8'h33, 0, 0};
        vecs[7]  = '{1'b0, 16'h9203, 1'b1, 1'b0, 8'h00, 3, 8'hA5, 0, 0};
        vecs[8]  = '{1'b1, 16'h8FFF, 1'b1, 1'b0, 8'h00, 3, 8'h11, 0, 0};
        vecs[9]  = '{1'b1, 16'h9000, 1'b1, 1'b0, 8'h00, 3, 8'hFF, 0, 0};
        vecs[10] = '{1'b1, 16'h91FF, 1'b1, 1'b0, 8'h00, 3, 8'hFF, 0, 0};
        vecs[11] = '{1'b0, 16'hBFFF, 1'b1, 1'b0, 8'h00, 3, 8'hFF, 0, 0};
        vecs[12] = '{1'b1, 16'h8FFF, 1'b0, 1'b1, 8'h22, 2, 8'hFF, 1, 0};
        vecs[13] = '{1'b0, 16'h8FFF, 1'b1, 1'b0, 8'h00, 3, 8'h22, 0, 0};
        vecs[14] = '{1'b1, 16'h9300, 1'b0, 1'b1, 8'h10, 2, 8'hFF, 0, 0};

        reset_n = 1'b0;
        m0_addr = '0; m1_addr = '0; m0_wr_data = '0; m1_wr_data = '0;
        clear_reqs();
        #1;
        check("reset_outputs", 64'({m0_rd_data, m0_ready, m1_rd_data, m1_ready,
                                    mem_addr, mem_wr_data, ram_we, io_we}), 64'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].m, vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wd,
                    lat, rdat, ram_n, io_n, addr1, other_rdy, pulse_ok);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_rd_data", i), 64'(rdat), 64'(vecs[i].rdat));
            check($sformatf("v%0d_ram_we", i), 64'(ram_n), 64'(vecs[i].ram_n));
            check($sformatf("v%0d_io_we", i), 64'(io_n), 64'(vecs[i].io_n));
            check($sformatf("v%0d_mem_addr", i), 64'(addr1), 64'(vecs[i].addr));
            check($sformatf("v%0d_other_ready", i), 64'(other_rdy), 64'h0);
            check($sformatf("v%0d_single_pulse", i), 64'(pulse_ok), 64'h1);
        end

        // Reset in the middle of a read: everything clears immediately, no ready.
        @(negedge clk);
        m0_addr = 16'h1234; m0_rd_req = 1'b1;
        @(negedge clk);
        check("abort_launch", 64'(mem_addr), 64'h1234);
        #2 reset_n = 1'b0;
        #1;
        check("abort_outputs", 64'({m0_rd_data, m0_ready, m1_rd_data, m1_ready,
                                    mem_addr, mem_wr_data, ram_we, io_we}), 64'h0);
        m1_addr = 16'hC000; m1_rd_req = 1'b1;
        rst_rdy = 0;
        repeat (3) begin
            @(negedge clk);
            rst_rdy = rst_rdy + int'(m0_ready) + int'(m1_ready);
        end
        check("abort_no_ready", 64'(rst_rdy), 64'h0);

        // Both masters held after release: m0 first, then strict alternation.
        reset_n = 1'b1;
        n_ev = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (m0_ready && m1_ready) check("rr_dual_ready", 64'h1, 64'h0);
            if ((m0_ready || m1_ready) && n_ev < 4) begin
                ev_m[n_ev] = m1_ready;
                ev_c[n_ev] = c;
                ev_d[n_ev] = m1_ready ? m1_rd_data : m0_rd_data;
                n_ev++;
            end
        end
        clear_reqs();
        check("rr_event_count", 64'(n_ev), 64'h4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ev) begin
                check($sformatf("rr%0d_master", k), 64'(ev_m[k]), 64'(k % 2));
                check($sformatf("rr%0d_cycle", k), 64'(ev_c[k]), 64'(3 + 4 * k));
                check($sformatf("rr%0d_rd_data", k), 64'(ev_d[k]),
                      (k % 2 == 0) ? 64'h5A : 64'h4C);
            end
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
